// File: rtl/prog_ctrl_pkg.sv
// Shared types and helpers for the fetch-stage program counter with return stack.
package prog_ctrl_pkg;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_ZERO   = 2'd1,
        COND_NZERO  = 2'd2,
        COND_NEG    = 2'd3
    } cond_e;

    // Evaluate a branch/call condition against the ALU flags.
    function automatic logic cond_met_f(input cond_e c, input logic zero_flag, input logic neg_flag);
        logic met;
        case (c)
            COND_ALWAYS: met = 1'b1;
            COND_ZERO:   met = zero_flag;
            COND_NZERO:  met = ~zero_flag;
            COND_NEG:    met = neg_flag;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Register-based LIFO holding return addresses for CALL/RET.
// The parent never issues push and pop in the same cycle.
module pc_ret_stack
    import prog_ctrl_pkg::*;
#(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [W-1:0]     mem_q [DEPTH];

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == {CNT_W{1'b0}});
    assign depth = cnt_q;

    // Next entry count; a blocked push/pop leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Entry counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage: a push writes the slot indexed by the current count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && !full && (cnt_q == CNT_W'(i))) begin
                    mem_q[i] <= din;
                end else begin
                    mem_q[i] <= mem_q[i];
                end
            end
        end
    end

    // Top-of-stack read mux; reads zero when empty.
    always_comb begin
        top = {W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
                top = mem_q[i];
            end else begin
                top = top;
            end
        end
    end

endmodule

// File: rtl/prog_ctrl_stack.sv
// Program counter for the fetch stage: conditional/relative branches,
// CALL/RET through a hardware return stack, stall, sticky stack-error flags.
module prog_ctrl_stack
    import prog_ctrl_pkg::*;
#(
    parameter int PC_W        = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic [1:0]                         cond,
    input  logic                               rel,
    input  logic                               zero,
    input  logic                               neg,
    input  logic [PC_W-1:0]                    target,
    output logic [PC_W-1:0]                    PC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;

    logic            cond_met_s;
    logic [PC_W-1:0] inc_s;
    logic [PC_W-1:0] dest_s;
    logic            push_s;
    logic            pop_s;
    logic [PC_W-1:0] top_s;
    logic            full_s;
    logic            empty_s;

    assign cond_met_s = cond_met_f(cond_e'(cond), zero, neg);
    assign inc_s      = pc_q + PC_W'(1);
    // Adding the offset at PC_W bits is the same as sign-extending it and wrapping.
    assign dest_s     = rel ? (pc_q + target) : target;

    pc_ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (inc_s),
        .top   (top_s),
        .depth (depth),
        .full  (full_s),
        .empty (empty_s)
    );

    // Priority select: stall, ret, taken call, taken branch, sequential.
    always_comb begin
        pc_d   = pc_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!empty_s) begin
                pop_s = 1'b1;
                pc_d  = top_s;
            end else begin
                pc_d  = inc_s;
                unf_d = 1'b1;
            end
        end else if (call && cond_met_s) begin
            if (!full_s) begin
                push_s = 1'b1;
                pc_d   = dest_s;
            end else begin
                pc_d  = inc_s;
                ovf_d = 1'b1;
            end
        end else if (branch && cond_met_s) begin
            pc_d = dest_s;
        end else begin
            pc_d = inc_s;
        end
    end

    // PC and sticky error flag registers; flags clear only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= {PC_W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign PC        = pc_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_prog_ctrl_stack.sv
// Scoreboard bench for prog_ctrl_stack: directed scenarios plus random traffic
// against an abstract model (integer PC, queue-based return stack).
module tb_prog_ctrl_stack;

    localparam int PC_W   = 7;
    localparam int DEPTH  = 4;
    localparam int MODV   = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, branch, call, ret, rel, zero, neg;
    logic [1:0] cond;
    logic [6:0] target;
    logic [6:0] PC;
    logic [2:0] depth;
    logic       stack_ovf, stack_unf;

    prog_ctrl_stack #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .call(call),
        .ret(ret), .cond(cond), .rel(rel), .zero(zero), .neg(neg),
        .target(target), .PC(PC), .depth(depth),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int dep;
        int ovf;
        int unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int   m_pc;
    int   m_stk[$];
    int   m_ovf;
    int   m_unf;

    task automatic cmp(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Apply controls now and advance the model by one clock.
    task automatic drive(input bit st, input bit br, input bit ca, input bit re,
                         input int cd, input bit rl, input bit z, input bit n, input int tg);
        int   off, dst, inc;
        bit   met;
        exp_t e;
        stall = st; branch = br; call = ca; ret = re;
        cond = 2'(cd); rel = rl; zero = z; neg = n; target = 7'(tg);
        off = (tg >= MODV/2) ? tg - MODV : tg;
        dst = rl ? (((m_pc + off) % MODV) + MODV) % MODV : tg;
        inc = (m_pc + 1) % MODV;
        met = (cd == 0) ? 1'b1 : (cd == 1) ? z : (cd == 2) ? !z : n;
        if (st) begin
        end else if (re) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = inc; m_unf = 1; end
        end else if (ca && met) begin
            if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); m_pc = dst; end
            else begin m_pc = inc; m_ovf = 1; end
        end else if (br && met) begin
            m_pc = dst;
        end else begin
            m_pc = inc;
        end
        e.pc = m_pc; e.dep = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit st, input bit br, input bit ca, input bit re,
                       input int cd, input bit rl, input bit z, input bit n, input int tg);
        @(negedge clk);
        drive(st, br, ca, re, cd, rl, z, n, tg);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input int tg);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, tg);
    endtask

    // Directed check against literal values right after the next edge.
    task automatic chk(input string name, input int pc, input int dep, input int ovf, input int unf);
        @(posedge clk);
        #2;
        cmp({name, ".pc"}, int'(PC), pc);
        cmp({name, ".depth"}, int'(depth), dep);
        cmp({name, ".ovf"}, int'(stack_ovf), ovf);
        cmp({name, ".unf"}, int'(stack_unf), unf);
    endtask

    // Monitor: every edge with an outstanding expectation is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("sb.pc", int'(PC), e.pc);
            cmp("sb.depth", int'(depth), e.dep);
            cmp("sb.ovf", int'(stack_ovf), e.ovf);
            cmp("sb.unf", int'(stack_unf), e.unf);
        end
    end

    initial begin
        int waited;
        reset = 1'b1;
        stall = 0; branch = 0; call = 0; ret = 0; cond = 0; rel = 0;
        zero = 0; neg = 0; target = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("rst.pc", int'(PC), 0);
        cmp("rst.depth", int'(depth), 0);
        cmp("rst.flags", int'({stack_ovf, stack_unf}), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        chk("inc3", 'h03, 0, 0, 0);

        jmp('h7F);
        chk("jmp7f", 'h7F, 0, 0, 0);
        idle();
        chk("wrap", 'h00, 0, 0, 0);

        cyc(0, 1, 0, 0, 1, 0, 1, 0, 'h14);
        chk("zero_t", 'h14, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 'h14);
        chk("zero_f", 'h15, 0, 0, 0);
        cyc(0, 1, 0, 0, 3, 0, 0, 1, 'h30);
        chk("neg_t", 'h30, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 0, 1, 0, 'h50);
        chk("nzero_f", 'h31, 0, 0, 0);

        jmp('h10);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 'h7C);
        chk("rel_back", 'h0C, 0, 0, 0);
        jmp('h7E);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 'h05);
        chk("rel_wrap", 'h03, 0, 0, 0);

        jmp('h05);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h20);
        chk("call1", 'h20, 1, 0, 0);
        idle();
        idle();
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h40);
        chk("call2", 'h40, 2, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 'h55);
        chk("ret1", 'h23, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("ret2", 'h06, 0, 0, 0);

        jmp('h09);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("unf", 'h0A, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h10);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h20);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h30);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 'h40);
        chk("call4", 'h40, 4, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 'h50);
        chk("ovf", 'h41, 4, 1, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 'h60);
        chk("stall", 'h41, 4, 1, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("pop2", 'h21, 2, 1, 1);

        // Asynchronous reset between edges at depth 2
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        cmp("arst.pc", int'(PC), 0);
        cmp("arst.depth", int'(depth), 0);
        cmp("arst.flags", int'({stack_ovf, stack_unf}), 0);
        @(negedge clk);
        stall = 0; branch = 0; call = 0; ret = 0;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r < 10, $urandom_range(0, 2) == 0, r >= 10 && r < 35, r >= 35 && r < 55,
                int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 127)));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        cmp("sb.drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
